// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program image loader.
// The CHK state exists only when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
    ST_CHK   = 3'd4,
`endif
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam int LEN_BYTES  = 4;
  localparam int WORD_BYTES = 4;
  localparam logic [7:0] CHK_INIT = 8'h00;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte-to-word packer shared by the length field and data words.
// complete is raised combinationally in the cycle the final byte is accepted.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        complete
);

  logic [1:0]  cnt_reg;
  logic [23:0] part_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg  <= '0;
      part_reg <= '0;
    end else if (clear) begin
      cnt_reg  <= '0;
      part_reg <= '0;
    end else if (take) begin
      cnt_reg  <= cnt_reg + 2'd1;
      part_reg <= {data, part_reg[23:8]};
    end
  end

  // Earlier bytes sit in the low lanes, so the incoming byte is the top lane.
  assign word     = {data, part_reg};
  assign complete = take && (cnt_reg == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed program image into core memory, holding the core in reset.
// Optional trailing XOR checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam longint unsigned CAPACITY = (64'd1 << ADDR_W) - 64'(BASE_ADDR);
  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

  state_t              state_reg, state_next;
  logic [ADDR_W:0]     len_reg;
  logic [ADDR_W:0]     idx_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [31:0]         mem_wdata_reg;
  logic                take;
  logic                start_ok;
  logic                pk_take;
  logic [31:0]         pk_word;
  logic                pk_complete;
  logic                len_too_big;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          xor_reg;
`endif

  assign take        = in_valid && in_ready;
  assign start_ok    = start && (state_reg == ST_IDLE || state_reg == ST_DONE || state_reg == ST_ERR);
  assign pk_take     = take && (state_reg == ST_LEN || state_reg == ST_DATA);
  assign len_too_big = 64'(pk_word) > CAPACITY;

  byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ok),
    .take     (pk_take),
    .data     (in_data),
    .word     (pk_word),
    .complete (pk_complete)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_next = ST_LEN;
      ST_LEN: begin
        if (pk_complete) begin
          if (len_too_big) state_next = ST_ERR;
`ifdef PROG_LOADER_CHECKSUM_EN
          else if (pk_word == 32'd0) state_next = ST_CHK;
`else
          else if (pk_word == 32'd0) state_next = ST_DONE;
`endif
          else state_next = ST_DATA;
        end
      end
      ST_DATA: if (pk_complete) state_next = ST_WRITE;
      ST_WRITE: begin
        if ((idx_reg + ONE) < len_reg) state_next = ST_DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
        else state_next = ST_CHK;
`else
        else state_next = ST_DONE;
`endif
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHK: if (take) state_next = (in_data == xor_reg) ? ST_DONE : ST_ERR;
`endif
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  assign in_ready = (state_reg == ST_LEN) || (state_reg == ST_DATA) || (state_reg == ST_CHK);
  assign busy     = (state_reg == ST_LEN) || (state_reg == ST_DATA) ||
                    (state_reg == ST_WRITE) || (state_reg == ST_CHK);
`else
  assign in_ready = (state_reg == ST_LEN) || (state_reg == ST_DATA);
  assign busy     = (state_reg == ST_LEN) || (state_reg == ST_DATA) || (state_reg == ST_WRITE);
`endif
  assign mem_we    = (state_reg == ST_WRITE);
  assign done      = (state_reg == ST_DONE);
  assign error     = (state_reg == ST_ERR);
  assign core_rst  = (state_reg != ST_DONE);
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      len_reg       <= '0;
      idx_reg       <= '0;
      mem_addr_reg  <= ADDR_W'(BASE_ADDR);
      mem_wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        len_reg <= '0;
        idx_reg <= '0;
      end
      if (state_reg == ST_LEN && pk_complete && !len_too_big)
        len_reg <= pk_word[ADDR_W:0];
      // Address and data are captured on entry to WRITE and then held.
      if (state_reg == ST_DATA && pk_complete) begin
        mem_addr_reg  <= ADDR_W'(BASE_ADDR) + idx_reg[ADDR_W-1:0];
        mem_wdata_reg <= pk_word;
      end
      if (state_reg == ST_WRITE)
        idx_reg <= idx_reg + ONE;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      xor_reg <= CHK_INIT;
    else if (start_ok)
      xor_reg <= CHK_INIT;
    else if (state_reg == ST_DATA && take)
      xor_reg <= xor_reg ^ in_data;
  end
`endif

endmodule
